// File: rtl/dir_input_fsm.sv
// Direction-input controller: per-button 2-FF synchroniser and debounce,
// press/hold/auto-repeat FSM producing one-cycle move strobes, and a sticky
// game-over state that is left only through clear or reset.
module dir_input_fsm #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter int unsigned IDX_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_n,
  input  logic             end_flag,
  input  logic             clear,
  output logic             move_valid,
  output logic [IDX_W-1:0] move_idx,
  output logic             held,
  output logic             game_over,
  output logic [2:0]       state_o
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RC_W   = $clog2(RC_MAX + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESS    = 3'd1,
    S_HOLD     = 3'd2,
    S_REPEAT   = 3'd3,
    S_WAIT_REL = 3'd4,
    S_OVER     = 3'd5
  } state_e;

  state_e                       state_q, state_d;
  logic [N_BTN-1:0]             sync1_q, sync2_q;
  logic [N_BTN-1:0]             db_q, db_d;
  logic [N_BTN-1:0][DB_W-1:0]   dbc_q, dbc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [RC_W-1:0]              rcnt_q, rcnt_d, rcnt_inc;

  logic [N_BTN-1:0] pressed;
  logic             any_pressed;
  logic             lat_pressed;
  logic             other_pressed;
  logic             found;
  logic [IDX_W-1:0] low_idx;
  logic             delay_hit;
  logic             rate_hit;

  // Two-stage synchroniser; reset to the released (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatches, toggle the level on the last one
  always_comb begin
    db_d  = db_q;
    dbc_d = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounced level and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q  <= '1;
      dbc_q <= '0;
    end else begin
      db_q  <= db_d;
      dbc_q <= dbc_d;
    end
  end

  assign pressed     = ~db_q;
  assign any_pressed = |pressed;

  // Lowest pressed index, and whether the latched / any other button is down
  always_comb begin
    low_idx       = '0;
    found         = 1'b0;
    lat_pressed   = 1'b0;
    other_pressed = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (pressed[i] && !found) begin
        low_idx = IDX_W'(i);
        found   = 1'b1;
      end
      if (IDX_W'(i) == idx_q) begin
        lat_pressed = pressed[i];
      end else if (pressed[i]) begin
        other_pressed = 1'b1;
      end
    end
  end

  // Repeat counter saturates; it starts from 0 on entry to PRESS so that the
  // first repeat lands REPEAT_DELAY cycles after the initial pulse.
  assign rcnt_inc  = (&rcnt_q) ? rcnt_q : rcnt_q + RC_W'(1);
  assign delay_hit = (REPEAT_DELAY != 0) && (32'(rcnt_q) >= REPEAT_DELAY - 1);
  assign rate_hit  = (32'(rcnt_q) >= REPEAT_RATE - 1);

  // Next-state logic: clear beats end_flag beats normal transitions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_inc;
    if (clear) begin
      state_d = S_WAIT_REL;
    end else if (end_flag && state_q != S_OVER) begin
      state_d = S_OVER;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_pressed) begin
            idx_d   = low_idx;
            rcnt_d  = '0;
            state_d = S_PRESS;
          end
        end
        S_PRESS: state_d = S_HOLD;
        S_HOLD: begin
          if (!lat_pressed) begin
            state_d = S_IDLE;
          end else if (other_pressed) begin
            state_d = S_WAIT_REL;
          end else if (delay_hit) begin
            rcnt_d  = '0;
            state_d = S_REPEAT;
          end
        end
        S_REPEAT: begin
          if (!lat_pressed) begin
            state_d = S_IDLE;
          end else if (other_pressed) begin
            state_d = S_WAIT_REL;
          end else if (rate_hit) begin
            rcnt_d = '0;
          end
        end
        S_WAIT_REL: begin
          if (!any_pressed) state_d = S_IDLE;
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state, latched index and repeat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // A REPEAT cycle with a freshly restarted counter is a repeat pulse
  always_comb begin
    move_valid = (state_q == S_PRESS) || (state_q == S_REPEAT && rcnt_q == '0);
    move_idx   = idx_q;
    held       = (state_q == S_HOLD) || (state_q == S_REPEAT);
    game_over  = (state_q == S_OVER);
    state_o    = state_q;
  end

endmodule

// File: tb/tb_dir_input_fsm.sv
// Directed bench for dir_input_fsm with DEBOUNCE_CYC=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Cycle numbers count posedges from the first edge that
// samples a new btn_n value (that edge is cycle 1).
module tb_dir_input_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n;
  logic       end_flag;
  logic       clear;
  logic       move_valid;
  logic [1:0] move_idx;
  logic       held;
  logic       game_over;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pcyc[$];
  int pidx[$];
  int exp_c[$];
  int exp_i[$];

  dir_input_fsm #(
    .N_BTN(4),
    .DEBOUNCE_CYC(4),
    .REPEAT_DELAY(20),
    .REPEAT_RATE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_n(btn_n),
    .end_flag(end_flag),
    .clear(clear),
    .move_valid(move_valid),
    .move_idx(move_idx),
    .held(held),
    .game_over(game_over),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each edge and logging pulses
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (move_valid === 1'b1) begin
        pcyc.push_back(cyc);
        pidx.push_back(int'(move_idx));
      end
    end
  endtask

  task automatic new_test();
    cyc = 0;
    pcyc.delete();
    pidx.delete();
  endtask

  // Compare logged pulses against exp_c / exp_i
  task automatic chk_pulses(input string tag);
    chk({tag, "_count"}, pcyc.size(), exp_c.size());
    for (int i = 0; i < exp_c.size(); i++) begin
      if (i < pcyc.size()) begin
        chk({tag, "_cyc"}, pcyc[i], exp_c[i]);
        chk({tag, "_idx"}, pidx[i], exp_i[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    btn_n    = 4'b1111;
    end_flag = 1'b0;
    clear    = 1'b0;
    tick(2);
    chk("rst_state", state_o, 0);
    chk("rst_mv", move_valid, 0);
    chk("rst_idx", move_idx, 0);
    chk("rst_held", held, 0);
    chk("rst_go", game_over, 0);
    rst = 1'b0;
    tick(3);

    // 1: 3-cycle glitch on button 2 is filtered
    new_test();
    btn_n = 4'b1011;
    tick(3);
    btn_n = 4'b1111;
    tick(12);
    chk("t1_state", state_o, 0);
    exp_c = {}; exp_i = {};
    chk_pulses("t1");

    // 2: single press of button 1
    new_test();
    btn_n = 4'b1101;
    tick(6);
    chk("t2_mv_c6", move_valid, 0);
    tick(1);
    chk("t2_mv_c7", move_valid, 1);
    chk("t2_state_c7", state_o, 1);
    chk("t2_idx_c7", move_idx, 1);
    tick(1);
    chk("t2_state_c8", state_o, 2);
    chk("t2_held_c8", held, 1);
    tick(2);
    btn_n = 4'b1111;
    tick(20);
    chk("t2_state_end", state_o, 0);
    exp_c = {7}; exp_i = {1};
    chk_pulses("t2");

    // 3: button 0 held for 60 cycles, auto-repeat; release wins at cycle 67
    new_test();
    btn_n = 4'b1110;
    tick(7);
    chk("t3_held_c7", held, 0);
    tick(1);
    chk("t3_held_c8", held, 1);
    tick(19);
    chk("t3_state_c27", state_o, 3);
    tick(33);
    btn_n = 4'b1111;
    tick(6);
    chk("t3_held_c66", held, 1);
    tick(1);
    chk("t3_held_c67", held, 0);
    chk("t3_state_c67", state_o, 0);
    tick(10);
    exp_c = {7, 27, 35, 43, 51, 59}; exp_i = {0, 0, 0, 0, 0, 0};
    chk_pulses("t3");

    // 4: buttons 2 and 3 together, then button 0 added: chord, no repeats
    new_test();
    btn_n = 4'b0011;
    tick(7);
    chk("t4_idx_c7", move_idx, 2);
    tick(2);
    chk("t4_state_c9", state_o, 4);
    tick(3);
    btn_n = 4'b0010;
    tick(28);
    chk("t4_state_c40", state_o, 4);
    chk("t4_held_c40", held, 0);
    exp_c = {7}; exp_i = {2};
    chk_pulses("t4");
    btn_n = 4'b1111;
    tick(15);
    chk("t4_state_rel", state_o, 0);

    // 5: end_flag on the edge where the first repeat is due
    new_test();
    btn_n = 4'b1110;
    tick(26);
    end_flag = 1'b1;
    tick(1);
    end_flag = 1'b0;
    chk("t5_state_c27", state_o, 5);
    chk("t5_go_c27", game_over, 1);
    chk("t5_mv_c27", move_valid, 0);
    btn_n = 4'b1101;
    tick(20);
    chk("t5_state_end", state_o, 5);
    chk("t5_go_end", game_over, 1);
    exp_c = {7}; exp_i = {0};
    chk_pulses("t5");

    // 6: clear while button 3 is held; a move needs release then new press
    new_test();
    btn_n = 4'b0111;
    tick(10);
    chk("t6_state_over", state_o, 5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("t6_state_clr", state_o, 4);
    chk("t6_go_clr", game_over, 0);
    tick(15);
    chk("t6_state_held", state_o, 4);
    btn_n = 4'b1111;
    tick(10);
    chk("t6_state_rel", state_o, 0);
    exp_c = {}; exp_i = {};
    chk_pulses("t6a");
    new_test();
    btn_n = 4'b0111;
    tick(10);
    exp_c = {7}; exp_i = {3};
    chk_pulses("t6b");
    btn_n = 4'b1111;
    tick(15);

    // 7: asynchronous reset in the middle of a hold
    new_test();
    btn_n = 4'b1011;
    tick(10);
    chk("t7_state_hold", state_o, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_state_rst", state_o, 0);
    chk("t7_held_rst", held, 0);
    chk("t7_idx_rst", move_idx, 0);
    btn_n = 4'b1111;
    tick(2);
    rst = 1'b0;
    new_test();
    tick(10);
    chk("t7_state_after", state_o, 0);
    exp_c = {}; exp_i = {};
    chk_pulses("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
